// File: rtl/ad9361_stim_pkg.sv
// Shared definitions for the AD9361 receive-interface stimulus source and its
// future capture checker: widths, the sample-word layout, the serializer state
// and the slot-to-nibble / rx_frame mapping.
package ad9361_stim_pkg;

    localparam int NIB_W  = 6;
    localparam int SAMP_W = 12;
    localparam int SLOT_W = 3;

    typedef logic [SAMP_W-1:0] samp_t;
    typedef logic [NIB_W-1:0]  nib_t;

    // One FIFO entry: a full 2R2T sample set (i1/q1 unused in 1R1T)
    typedef struct packed {
        samp_t i0;
        samp_t q0;
        samp_t i1;
        samp_t q1;
    } stim_word_t;

    localparam int WORD_W = $bits(stim_word_t);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stim_state_t;

    typedef struct packed {
        logic frame;
        nib_t data;
    } slot_out_t;

    // Slot k carries sample k/2 (I0,Q0,I1,Q1), high half first. rx_frame is
    // high for the first half of the frame: slots 0-1 in 1R1T, 0-3 in 2R2T.
    function automatic slot_out_t slot_map(input stim_word_t w,
                                           input logic [SLOT_W-1:0] slot,
                                           input logic r1);
        samp_t     s;
        slot_out_t o;
        case (slot[2:1])
            2'd0:    s = w.i0;
            2'd1:    s = w.q0;
            2'd2:    s = w.i1;
            default: s = w.q1;
        endcase
        o.data  = slot[0] ? s[NIB_W-1:0] : s[SAMP_W-1:NIB_W];
        o.frame = r1 ? (slot[2:1] == 2'd0) : !slot[2];
        return o;
    endfunction

endpackage

// File: rtl/ad9361_rx_stim_fifo.sv
// Generic synchronous FIFO with a registered (non fall-through) read port.
// Writes when full and reads when empty are ignored. full/empty are registers.
module stim_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_INC  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_INC  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Occupancy after this cycle's accepted write and/or read
    always_comb begin
        // NOTE: default first so every path assigns count_nxt; no latch is inferred.
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CNT_INC;
            2'b01:   count_nxt = count - CNT_INC;
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and registered status flags
    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments in clocked logic so every register sees pre-edge values.
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_INC;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_INC;
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
        end
    end

    // Storage array
    always_ff @(posedge sys_clk) begin
        // NOTE: storage is deliberately not reset; pointers define validity, and a reset-free array maps to RAM.
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // Registered read port: data appears the cycle after the pop
    always_ff @(posedge sys_clk) begin
        if (sys_rst)    rd_data <= '0;
        else if (rd_ok) rd_data <= mem[rd_ptr];
    end

endmodule

// File: rtl/ad9361_rx_stim.sv
// AD9361 receive-interface stimulus source. Buffers I/Q sample words and
// serializes them into the 6-bit rx_data / rx_frame nibble stream in 1R1T or
// 2R2T framing, emitting all-zero frames and counting underflows when starved.
module ad9361_rx_stim
    import ad9361_stim_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 enable,
    input  logic                 r1_mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [SAMP_W-1:0]    s_data_i0,
    input  logic [SAMP_W-1:0]    s_data_q0,
    input  logic [SAMP_W-1:0]    s_data_i1,
    input  logic [SAMP_W-1:0]    s_data_q1,
    output logic                 rx_frame,
    output logic [NIB_W-1:0]     rx_data,
    output logic                 rx_strobe,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] underflow_cnt,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_INC = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    stim_state_t       state;
    stim_state_t       state_nxt;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_nxt;
    logic [SLOT_W-1:0] last_slot;
    logic              mode_r1;
    logic              frame_start;
    logic              frame_ufl;
    logic              fifo_full;
    logic              fifo_empty;
    stim_word_t        wr_word;
    stim_word_t        rd_word;
    slot_out_t         cur;

    assign wr_word   = '{i0: s_data_i0, q0: s_data_q0, i1: s_data_i1, q1: s_data_q1};
    assign s_ready   = !fifo_full;
    assign last_slot = mode_r1 ? 3'd3 : 3'd7;

    // The pop happens on the edge that enters slot 0, so the popped word is
    // already in rd_word while slot 0 is being registered onto rx_data.
    stim_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_en   (s_valid),
        .wr_data (wr_word),
        .rd_en   (frame_start),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next state / slot; frame_start marks the edge that begins a new frame
    always_comb begin
        state_nxt   = state;
        slot_nxt    = slot;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                slot_nxt = '0;
                if (enable) begin
                    state_nxt   = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (slot == last_slot) begin
                    slot_nxt = '0;
                    if (enable) frame_start = 1'b1;
                    else        state_nxt   = IDLE;
                end else begin
                    slot_nxt = slot + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, slot, per-frame mode and per-frame underflow flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            slot      <= '0;
            mode_r1   <= 1'b0;
            frame_ufl <= 1'b0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
            // Mode only changes between frames, so a frame never changes length
            if (state == IDLE || frame_start) mode_r1 <= r1_mode;
            if (frame_start) frame_ufl <= fifo_empty;
        end
    end

    // Frame and underflow counters, updated once per frame at its start
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            underflow_cnt <= '0;
            frame_cnt     <= '0;
        end else if (frame_start) begin
            if (fifo_empty) begin
                if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + CNT_INC;
            end else begin
                frame_cnt <= frame_cnt + CNT_INC;
            end
        end
    end

    assign cur = slot_map(rd_word, slot, mode_r1);

    // Registered pad outputs; underflow frames keep rx_frame but zero the data
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_frame  <= 1'b0;
            rx_data   <= '0;
            rx_strobe <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_frame  <= (state == RUN) && cur.frame;
            rx_data   <= (state == RUN && !frame_ufl) ? cur.data : '0;
            rx_strobe <= (state == RUN);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_ad9361_rx_stim.sv
// Directed bench for ad9361_rx_stim: expected nibbles are queued when words
// are pushed and compared whenever the DUT strobes a nibble out.
module tb_ad9361_rx_stim;
    import ad9361_stim_pkg::*;

    logic        sys_clk;
    logic        sys_rst;
    logic        enable;
    logic        r1_mode;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_data_i0;
    logic [11:0] s_data_q0;
    logic [11:0] s_data_i1;
    logic [11:0] s_data_q1;
    logic        rx_frame;
    logic [5:0]  rx_data;
    logic        rx_strobe;
    logic        busy;
    logic [15:0] underflow_cnt;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;
    logic [6:0] exp_q[$];

    ad9361_rx_stim #(
        .FIFO_DEPTH (8),
        .CNT_WIDTH  (16)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .enable        (enable),
        .r1_mode       (r1_mode),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data_i0     (s_data_i0),
        .s_data_q0     (s_data_q0),
        .s_data_i1     (s_data_i1),
        .s_data_q1     (s_data_q1),
        .rx_frame      (rx_frame),
        .rx_data       (rx_data),
        .rx_strobe     (rx_strobe),
        .busy          (busy),
        .underflow_cnt (underflow_cnt),
        .frame_cnt     (frame_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    // Expected {rx_frame, rx_data} sequence for one frame
    function automatic void push_frame(input stim_word_t w, input bit r1, input bit ufl);
        logic [11:0] samp [4];
        logic [5:0]  nib;
        int          n;
        samp = '{w.i0, w.q0, w.i1, w.q1};
        n = r1 ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            for (int h = 0; h < 2; h++) begin
                nib = (h == 0) ? samp[i][11:6] : samp[i][5:0];
                if (ufl) nib = 6'h00;
                exp_q.push_back({((2 * i + h) < n) ? 1'b1 : 1'b0, nib});
            end
        end
    endfunction

    task automatic send_word(input stim_word_t w);
        int n;
        n = 0;
        s_data_i0 = w.i0;
        s_data_q0 = w.q0;
        s_data_i1 = w.i1;
        s_data_q1 = w.q1;
        s_valid   = 1'b1;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frame_cnt != 16'(target) && n < 300) begin
            tick();
            n++;
        end
        check("frame_cnt_reach", frame_cnt, target);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        tick();
        check("idle_strobe", rx_strobe, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    // Scoreboard: every strobed nibble must match the queue head; outside
    // RUN the pads must be zero
    always @(negedge sys_clk) begin
        logic [6:0] e;
        if (rx_strobe) begin
            check("nibble_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("nibble", {rx_frame, rx_data}, e);
            end
        end else begin
            check("pads_zero", {rx_frame, rx_data}, 7'h00);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_word_t w;
        stim_word_t wa;
        stim_word_t wb;

        sys_rst   = 1'b1;
        enable    = 1'b0;
        r1_mode   = 1'b1;
        s_valid   = 1'b0;
        s_data_i0 = '0;
        s_data_q0 = '0;
        s_data_i1 = '0;
        s_data_q1 = '0;
        repeat (2) tick();

        // Reset state
        check("rst_frame", rx_frame, 1'b0);
        check("rst_data", rx_data, 6'h00);
        check("rst_strobe", rx_strobe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", s_ready, 1'b1);
        check("rst_ufl", underflow_cnt, 16'd0);
        check("rst_frames", frame_cnt, 16'd0);
        sys_rst = 1'b0;
        tick();

        // 1R1T frame, then an underflow frame; enable dropped at its slot 1
        r1_mode = 1'b1;
        w = '{i0: 12'hABC, q0: 12'h123, i1: 12'h000, q1: 12'h000};
        send_word(w);
        push_frame(w, 1'b1, 1'b0);
        push_frame('0, 1'b1, 1'b1);
        enable = 1'b1;
        tick();
        check("t1_busy_first", busy, 1'b1);
        check("t1_strobe_first", rx_strobe, 1'b0);
        tick();
        check("t1_slot0", {rx_frame, rx_data}, {1'b1, 6'h2A});
        repeat (4) tick();
        enable = 1'b0;
        drain();
        check("t1_frames", frame_cnt, 16'd1);
        check("t1_ufl", underflow_cnt, 16'd1);

        // 2R2T single frame with boundary sample values
        r1_mode = 1'b0;
        w = '{i0: 12'h800, q0: 12'h7FF, i1: 12'h001, q1: 12'hFFF};
        send_word(w);
        push_frame(w, 1'b0, 1'b0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        drain();
        check("t2_frames", frame_cnt, 16'd2);
        check("t2_ufl", underflow_cnt, 16'd1);

        // Backpressure: 9 words against an 8-deep FIFO
        r1_mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = '{i0: 12'(k * 291 + 5), q0: 12'(~(k * 37)), i1: 12'h000, q1: 12'h000};
            s_data_i0 = w.i0;
            s_data_q0 = w.q0;
            s_data_i1 = w.i1;
            s_data_q1 = w.q1;
            s_valid   = 1'b1;
            check("bp_ready_fill", s_ready, 1'b1);
            push_frame(w, 1'b1, 1'b0);
            tick();
        end
        check("bp_ready_full", s_ready, 1'b0);
        w = '{i0: 12'hE5D, q0: 12'h0C3, i1: 12'h000, q1: 12'h000};
        s_data_i0 = w.i0;
        s_data_q0 = w.q0;
        push_frame(w, 1'b1, 1'b0);
        enable = 1'b1;
        tick();
        check("bp_ready_after_pop", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        wait_frames(11);
        enable = 1'b0;
        drain();
        check("t3_ufl", underflow_cnt, 16'd1);

        // Mode change at slot 2: current frame stays 4 slots, next is 8
        r1_mode = 1'b1;
        wa = '{i0: 12'h5A5, q0: 12'hA5A, i1: 12'h3C3, q1: 12'hC3C};
        wb = '{i0: 12'h0F0, q0: 12'h123, i1: 12'h456, q1: 12'h789};
        send_word(wa);
        send_word(wb);
        push_frame(wa, 1'b1, 1'b0);
        push_frame(wb, 1'b0, 1'b0);
        enable = 1'b1;
        repeat (3) tick();
        r1_mode = 1'b0;
        wait_frames(13);
        enable = 1'b0;
        drain();
        check("t4_ufl", underflow_cnt, 16'd1);

        // Reset at slot 5 of a 2R2T frame with 3 words still queued
        r1_mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = '{i0: 12'(k + 1), q0: 12'(k + 2), i1: 12'(k + 3), q1: 12'(k + 4)};
            send_word(w);
            if (k == 0) push_frame(w, 1'b0, 1'b0);
        end
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (5) tick();
        sys_rst = 1'b1;
        tick();
        check("t5_rst_frame", rx_frame, 1'b0);
        check("t5_rst_data", rx_data, 6'h00);
        check("t5_rst_strobe", rx_strobe, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_ready", s_ready, 1'b1);
        check("t5_rst_ufl", underflow_cnt, 16'd0);
        check("t5_rst_frames", frame_cnt, 16'd0);
        check("t5_slots_cut", exp_q.size(), 3);
        exp_q.delete();
        sys_rst = 1'b0;
        r1_mode = 1'b1;
        tick();
        push_frame('0, 1'b1, 1'b1);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        drain();
        check("t5_ufl", underflow_cnt, 16'd1);
        check("t5_frames", frame_cnt, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ad9361_rx_stim.md
# ad9361_rx_stim

Synthesizable AD9361 receive-interface stimulus source for the gateway simulation top. It accepts 12-bit I/Q sample pairs over a valid/ready stream and buffers them in a small FIFO. It serializes them into the AD9361 6-bit nibble stream (rx_frame / rx_data) that is presented to the axi_ad9361 receive path of system_top. It supports 1R1T and 2R2T framing and counts underflows, so benches can drive known sample sequences instead of a free-running ramp.

## Interface
Parameters:
- FIFO_DEPTH, 8: sample-word FIFO depth, power of two, at least 2.
- CNT_WIDTH, 16: width of the status counters.

Ports:
- sys_clk  in  1  Nibble-rate clock. One rx_data nibble per cycle.
- sys_rst  in  1  Reset, synchronous, active-high.
- enable  in  1  Run request for the serializer.
- r1_mode  in  1  1 = one channel (I0/Q0 only), 0 = two channels.
- s_valid  in  1  Input sample word valid.
- s_ready  out  1  FIFO can accept a word; equals !full.
- s_data_i0, s_data_q0, s_data_i1, s_data_q1  in  12 each  Two's-complement samples. i1/q1 are ignored when r1_mode=1.
- rx_frame  out  1  Frame signal.
- rx_data  out  6  Nibble.
- rx_strobe  out  1  High while in RUN, including underflow frames.
- busy  out  1  State is not IDLE.
- underflow_cnt  out  CNT_WIDTH  Frames emitted with an empty FIFO. Saturates at all-ones.
- frame_cnt  out  CNT_WIDTH  Frames emitted from FIFO data. Wraps.

## Operation
- FIFO stores {i0,q0,i1,q1} (48 bits). A write occurs when s_valid && s_ready. It is not first-word-fall-through.
- Frame length L is 4 slots when r1_mode=1 and 8 slots otherwise. r1_mode is latched only in IDLE and at slot 0. A mid-frame change of r1_mode takes effect on the next frame.
- Slot order within a frame:
  - 1R1T: I0[11:6], I0[5:0], Q0[11:6], Q0[5:0]. rx_frame is 1,1,0,0.
  - 2R2T: I0 hi/lo, Q0 hi/lo, I1 hi/lo, Q1 hi/lo. rx_frame is 1,1,1,1,0,0,0,0.
- States:
  - IDLE: outputs are zero. On enable=1, go to RUN with slot=0.
  - RUN: at slot 0, pop the FIFO if it is non-empty and increment frame_cnt. If the FIFO is empty, the data nibbles for that frame are 0, the rx_frame pattern is unchanged, and underflow_cnt increments. slot counts 0 to L-1, then wraps.
  - If enable=0 at the last slot, go to IDLE after that slot. Otherwise start a new frame.
  - RUN never aborts mid-frame. A complete frame is always emitted.
- Simultaneous FIFO write and pop at slot 0: both happen and the FIFO count is unchanged.
- When full, s_ready=0. A pop in a cycle raises s_ready in the next cycle.

## Timing
- Reset values: rx_frame=0, rx_data=0, rx_strobe=0, busy=0, s_ready=1, both counters=0, FIFO empty, state=IDLE, slot=0.
- sys_rst asserted mid-frame takes effect at the next edge. The FIFO contents are discarded.
- All outputs are registered.
- Word written at edge N, enable already high, and serializer at slot 0 with the FIFO previously empty: the pop decision is at edge N+1. The first nibble is on rx_data after edge N+2.
- enable rising at edge E while in IDLE: slot 0 is driven after edge E+1.
- Throughput is one word per L cycles. A steady stream needs s_valid at least once per L cycles.
- rx_data is stable for the whole cycle. The receiver samples it on the next rising edge.

## Structure
- Shared package ad9361_stim_pkg contains:
  - NIB_W=6 and SAMP_W=12
  - the word typedef {i0,q0,i1,q1}
  - the state enum {IDLE, RUN}
  - the slot-to-field and rx_frame mapping function, shared with the future capture checker
- One sub-module, stim_sync_fifo: a generic synchronous FIFO with width/depth parameters and full/empty outputs.

## Test plan
- 1R1T: r1_mode=1, push I0=0xABC, Q0=0x123, enable=1. rx_data is 0x2A, 0x3C, 0x04, 0x23 with rx_frame 1,1,0,0. frame_cnt=1. The next frame is an underflow frame (all zeros) and underflow_cnt=1.
- 2R2T: r1_mode=0, push {0x800, 0x7FF, 0x001, 0xFFF}. rx_data is 20,00,1F,3F,00,01,3F,3F (hex) with rx_frame 1,1,1,1,0,0,0,0.
- Backpressure: enable=0, s_valid held for 9 words. s_ready falls after 8 accepted words. Then enable=1. s_ready returns 1 cycle after the first pop. The 9th word is emitted 9th, and no words are lost or reordered.
- Enable drop: deassert enable at slot 1 of a 1R1T frame. Slots 2 and 3 are still emitted, then rx_strobe=0 and busy=0.
- Mode change at slot 2: the current frame stays 4 slots long and the next frame is 8 slots long.
- Reset mid-frame at slot 5 with 3 words queued: all outputs are at reset values after the edge. On re-enable, the first frame is an underflow frame.
